// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the unified memory arbiter.
// slave is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access, one access at a
// time, with fixed memory latency, one-cycle acks and per-stage stall lines.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CntW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              owner_d_q;  // 1: data port owns the access in flight
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_ack_q;
  logic              d_ack_q;
  logic              grant_d;
  logic              grant_if;

  // Data wins over fetch; in ACK the port being acked still holds req and must be skipped.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (state_q == StIdle) begin
      grant_d  = bus.d_req;
      grant_if = bus.if_req & ~bus.d_req;
    end else if (state_q == StAck) begin
      if (owner_d_q) begin
        grant_if = bus.if_req;
      end else begin
        grant_d = bus.d_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      owner_d_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      unique case (state_q)
        StIdle, StAck: begin
          if (grant_d || grant_if) begin
            state_q     <= StIssue;
            owner_d_q   <= grant_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_d & bus.d_we;
            mem_addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
            mem_wdata_q <= bus.d_wdata;
            cnt_q       <= CntW'(MEM_LAT);
          end else begin
            state_q <= StIdle;
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          cnt_q <= cnt_q - 1'b1;
          // cnt_q == 1 marks the cycle mem_rdata is valid
          if (cnt_q == CntW'(1)) begin
            state_q <= StAck;
            if (owner_d_q) begin
              d_ack_q <= 1'b1;
              if (!mem_we_q) begin
                d_rdata_q <= bus.mem_rdata;
              end
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = bus.d_req & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) checked every cycle against a
// schedule-based model, plus directed scenarios pinned by literal expectations.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst), .bus(b1));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(rst), .bus(b3));

  // Index 0: MEM_LAT=1 instance, index 1: MEM_LAT=3 instance.
  logic        if_req[2], d_req[2], d_we[2];
  logic [31:0] if_addr[2], d_addr[2], d_wdata[2], mem_rdata[2];
  logic        o_if_ack[2], o_d_ack[2], o_mem_en[2], o_mem_we[2], o_sif[2], o_smem[2];
  logic [31:0] o_if_rdata[2], o_d_rdata[2], o_mem_addr[2], o_mem_wdata[2];

  assign b1.if_req = if_req[0];   assign b3.if_req = if_req[1];
  assign b1.if_addr = if_addr[0]; assign b3.if_addr = if_addr[1];
  assign b1.d_req = d_req[0];     assign b3.d_req = d_req[1];
  assign b1.d_we = d_we[0];       assign b3.d_we = d_we[1];
  assign b1.d_addr = d_addr[0];   assign b3.d_addr = d_addr[1];
  assign b1.d_wdata = d_wdata[0]; assign b3.d_wdata = d_wdata[1];
  assign b1.mem_rdata = mem_rdata[0]; assign b3.mem_rdata = mem_rdata[1];
  assign o_if_ack[0] = b1.if_ack;       assign o_if_ack[1] = b3.if_ack;
  assign o_d_ack[0] = b1.d_ack;         assign o_d_ack[1] = b3.d_ack;
  assign o_mem_en[0] = b1.mem_en;       assign o_mem_en[1] = b3.mem_en;
  assign o_mem_we[0] = b1.mem_we;       assign o_mem_we[1] = b3.mem_we;
  assign o_sif[0] = b1.stall_if;        assign o_sif[1] = b3.stall_if;
  assign o_smem[0] = b1.stall_mem;      assign o_smem[1] = b3.stall_mem;
  assign o_if_rdata[0] = b1.if_rdata;   assign o_if_rdata[1] = b3.if_rdata;
  assign o_d_rdata[0] = b1.d_rdata;     assign o_d_rdata[1] = b3.d_rdata;
  assign o_mem_addr[0] = b1.mem_addr;   assign o_mem_addr[1] = b3.mem_addr;
  assign o_mem_wdata[0] = b1.mem_wdata; assign o_mem_wdata[1] = b3.mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat[2] = '{1, 3};

  // Model: an access granted in cycle g shows mem_en in g+1 and acks in g+2+lat.
  bit          busy[2], own_d[2], m_we[2];
  int          g[2];
  logic [31:0] m_addr[2], m_wd[2], e_ifr[2], e_dr[2];
  // Bench memory: one outstanding issue per instance.
  bit          p_v[2];
  int          p_c[2];
  logic [31:0] p_a[2];
  bit          seen_ifack[2], seen_dack[2];
  int          cont_left = 0;

  // Directed-run logs, bit k = relative cycle k.
  logic [31:0] lg_men, lg_ifack, lg_dack, lg_sif, lg_smem, lg_we;
  logic [31:0] lg_addr[32], lg_wd[32], lg_ifr[32], lg_dr[32];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_000A;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (p_v[i] && (p_c[i] + lat[i] == cyc)) begin
        mem_rdata[i] = mem_word(p_a[i]);
        p_v[i] = 1'b0;
      end else begin
        mem_rdata[i] = $urandom();
      end
    end
  endtask

  task automatic model_cycle(input int i);
    bit    ack_c, e_men, gd, gi;
    string p;
    p = (i == 0) ? "L1" : "L3";
    ack_c = busy[i] && (cyc == g[i] + 2 + lat[i]);
    e_men = busy[i] && (cyc == g[i] + 1);
    if (ack_c && !own_d[i]) e_ifr[i] = mem_word(m_addr[i]);
    if (ack_c && own_d[i] && !m_we[i]) e_dr[i] = mem_word(m_addr[i]);
    chk({p, " mem_en"}, 32'(o_mem_en[i]), 32'(e_men));
    chk({p, " if_ack"}, 32'(o_if_ack[i]), 32'(ack_c && !own_d[i]));
    chk({p, " d_ack"}, 32'(o_d_ack[i]), 32'(ack_c && own_d[i]));
    chk({p, " if_rdata"}, o_if_rdata[i], e_ifr[i]);
    chk({p, " d_rdata"}, o_d_rdata[i], e_dr[i]);
    chk({p, " stall_if"}, 32'(o_sif[i]), 32'(if_req[i] && !(ack_c && !own_d[i])));
    chk({p, " stall_mem"}, 32'(o_smem[i]), 32'(d_req[i] && !(ack_c && own_d[i])));
    if (e_men) begin
      chk({p, " mem_addr"}, o_mem_addr[i], m_addr[i]);
      chk({p, " mem_we"}, 32'(o_mem_we[i]), 32'(m_we[i]));
      if (m_we[i]) chk({p, " mem_wdata"}, o_mem_wdata[i], m_wd[i]);
    end
    if (o_mem_en[i] === 1'b1) begin
      p_v[i] = 1'b1;
      p_c[i] = cyc;
      p_a[i] = o_mem_addr[i];
    end
    seen_ifack[i] = (o_if_ack[i] === 1'b1);
    seen_dack[i]  = (o_d_ack[i] === 1'b1);
    if (rst) begin
      busy[i] = 1'b0;
      e_ifr[i] = '0;
      e_dr[i] = '0;
      p_v[i] = 1'b0;
    end else if (!busy[i] || ack_c) begin
      gd = d_req[i] && !(ack_c && own_d[i]);
      gi = if_req[i] && !(ack_c && !own_d[i]);
      if (gd || gi) begin
        busy[i] = 1'b1;
        g[i] = cyc;
        own_d[i] = gd;
        m_we[i] = gd && d_we[i];
        m_addr[i] = gd ? d_addr[i] : if_addr[i];
        m_wd[i] = d_wdata[i];
      end else begin
        busy[i] = 1'b0;
      end
    end
  endtask

  task automatic cyc_end();
    @(negedge clk);
    for (int i = 0; i < 2; i++) model_cycle(i);
  endtask

  // Requesters hold req until ack, then drop or (rnd) raise a fresh request.
  task automatic drive_reqs(input bit rnd);
    for (int i = 0; i < 2; i++) begin
      if (seen_ifack[i]) begin
        if (i == 0 && cont_left > 0) begin
          cont_left--;
          if (cont_left == 0) if_req[0] = 1'b0;
          else if_addr[0] = if_addr[0] + 32'd4;
        end else begin
          if_req[i] = 1'b0;
        end
      end
      if (seen_dack[i]) d_req[i] = 1'b0;
      if (rnd && !if_req[i] && $urandom_range(0, 2) != 0) begin
        if_req[i] = 1'b1;
        if_addr[i] = $urandom() & 32'hFFFF_FFFC;
      end
      if (rnd && !d_req[i] && $urandom_range(0, 3) == 0) begin
        d_req[i] = 1'b1;
        d_we[i] = 1'($urandom_range(0, 1));
        d_addr[i] = $urandom() & 32'hFFFF_FFFC;
        d_wdata[i] = $urandom();
      end
    end
  endtask

  // Caller has done cyc_begin and set cycle-0 requests; runs n cycles logging instance i.
  task automatic dir_run(input int i, input int n, input int rst_at);
    lg_men = '0; lg_ifack = '0; lg_dack = '0; lg_sif = '0; lg_smem = '0; lg_we = '0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        cyc_begin();
        drive_reqs(1'b0);
        rst = (k == rst_at);
        if (k == rst_at + 1) begin
          if_req[i] = 1'b0;
          d_req[i] = 1'b0;
        end
      end
      cyc_end();
      lg_men[k] = o_mem_en[i];
      lg_ifack[k] = o_if_ack[i];
      lg_dack[k] = o_d_ack[i];
      lg_sif[k] = o_sif[i];
      lg_smem[k] = o_smem[i];
      lg_we[k] = o_mem_we[i] & o_mem_en[i];
      lg_addr[k] = o_mem_addr[i];
      lg_wd[k] = o_mem_wdata[i];
      lg_ifr[k] = o_if_rdata[i];
      lg_dr[k] = o_d_rdata[i];
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0; d_req[i] = 1'b0; d_we[i] = 1'b0;
      if_addr[i] = '0; d_addr[i] = '0; d_wdata[i] = '0; mem_rdata[i] = '0;
      busy[i] = 1'b0; own_d[i] = 1'b0; m_we[i] = 1'b0; g[i] = 0;
      m_addr[i] = '0; m_wd[i] = '0; e_ifr[i] = '0; e_dr[i] = '0;
      p_v[i] = 1'b0; p_c[i] = 0; p_a[i] = '0; seen_ifack[i] = 1'b0; seen_dack[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) begin
      cyc_begin();
      cyc_end();
    end
    for (int i = 0; i < 2; i++) begin
      chk("reset mem_addr", o_mem_addr[i], 32'h0);
      chk("reset mem_wdata", o_mem_wdata[i], 32'h0);
      chk("reset mem_we", 32'(o_mem_we[i]), 32'h0);
      chk("reset if_rdata", o_if_rdata[i], 32'h0);
    end

    // Single fetch, MEM_LAT=1.
    cyc_begin(); rst = 1'b0;
    if_req[0] = 1'b1; if_addr[0] = 32'h0040_0000;
    dir_run(0, 6, -1);
    chk("t1 mem_en", lg_men, 32'h02);
    chk("t1 if_ack", lg_ifack, 32'h08);
    chk("t1 stall_if", lg_sif, 32'h07);
    chk("t1 mem_addr", lg_addr[1], 32'h0040_0000);
    chk("t1 if_rdata", lg_ifr[3], 32'h2008_000A);

    // Fetch and load together: data first.
    cyc_begin();
    if_req[0] = 1'b1; if_addr[0] = 32'h0040_0004;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h1001_0004;
    dir_run(0, 8, -1);
    chk("t2 mem_en", lg_men, 32'h12);
    chk("t2 d_ack", lg_dack, 32'h08);
    chk("t2 if_ack", lg_ifack, 32'h40);
    chk("t2 stall_mem", lg_smem, 32'h07);
    chk("t2 stall_if", lg_sif, 32'h3F);
    chk("t2 data addr", lg_addr[1], 32'h1001_0004);
    chk("t2 fetch addr", lg_addr[4], 32'h0040_0004);
    chk("t2 d_rdata", lg_dr[3], mem_word(32'h1001_0004));

    // Store.
    cyc_begin();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h1001_0008; d_wdata[0] = 32'hDEAD_BEEF;
    dir_run(0, 5, -1);
    chk("t3 mem_en", lg_men, 32'h02);
    chk("t3 mem_we", lg_we, 32'h02);
    chk("t3 d_ack", lg_dack, 32'h08);
    chk("t3 stall_mem", lg_smem, 32'h07);
    chk("t3 mem_addr", lg_addr[1], 32'h1001_0008);
    chk("t3 mem_wdata", lg_wd[1], 32'hDEAD_BEEF);
    chk("t3 d_rdata held", lg_dr[3], mem_word(32'h1001_0004));

    // Four back-to-back fetches; the acked port is skipped in ACK so each takes 4 cycles.
    cont_left = 4;
    cyc_begin();
    if_req[0] = 1'b1; if_addr[0] = 32'h0040_0100;
    dir_run(0, 18, -1);
    chk("t4 if_ack", lg_ifack, 32'h0000_8888);
    chk("t4 mem_en", lg_men, 32'h0000_2222);
    chk("t4 mem_en adjacent", lg_men & (lg_men >> 1), 32'h0);
    chk("t4 last addr", lg_addr[13], 32'h0040_010C);
    chk("t4 last if_rdata", lg_ifr[15], mem_word(32'h0040_010C));

    // Reset during WAIT of a fetch.
    cyc_begin();
    if_req[0] = 1'b1; if_addr[0] = 32'h0040_0200;
    dir_run(0, 7, 2);
    chk("t5 mem_en", lg_men, 32'h02);
    chk("t5 if_ack", lg_ifack, 32'h00);
    chk("t5 if_rdata", lg_ifr[3], 32'h0);
    chk("t5 d_rdata", lg_dr[3], 32'h0);
    chk("t5 mem_addr", lg_addr[3], 32'h0);

    // Load with MEM_LAT=3.
    cyc_begin();
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h1001_0010;
    dir_run(1, 8, -1);
    chk("t6 mem_en", lg_men, 32'h02);
    chk("t6 d_ack", lg_dack, 32'h20);
    chk("t6 stall_mem", lg_smem, 32'h1F);
    chk("t6 mem_addr", lg_addr[1], 32'h1001_0010);
    chk("t6 d_rdata", lg_dr[5], mem_word(32'h1001_0010));

    // Random traffic with occasional resets on both instances.
    for (int n = 0; n < 3000; n++) begin
      cyc_begin();
      drive_reqs(1'b1);
      rst = ($urandom_range(0, 299) == 0);
      cyc_end();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
